// File: rtl/seq_isqrt.sv
// ============================================================================
//  Module   : seq_isqrt
//  Purpose  : Multi-cycle integer square root, restoring digit-by-digit method.
//             Retires two radicand bits per cycle using a single trial
//             subtract, producing floor(sqrt(din)) and the remainder
//             din - root*root.
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset
//             start  - request; accepted in IDLE or DONE
//             din    - WIDTH-bit unsigned radicand, sampled on acceptance
//             busy   - high while iterations are running
//             done   - one-cycle pulse, root/rem freshly updated
//             root   - WIDTH/2-bit root, held until the next done
//             rem    - (WIDTH/2+1)-bit remainder, held until the next done
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_isqrt #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     din,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH/2-1:0]   root,
    output logic [WIDTH/2:0]     rem
);

    localparam int N  = WIDTH / 2;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] rad_q,   rad_d;
    logic [N-1:0]    proot_q, proot_d;
    logic [N:0]      prem_q,  prem_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic [N-1:0]    root_q,  root_d;
    logic [N:0]      rem_q,   rem_d;

    // Trial subtract carried at N+3 bits so neither operand is truncated;
    // bit N+2 acts as the sign of the difference.
    logic [N+2:0] w_t;
    logic [N+2:0] w_trial;
    logic [N+2:0] w_diff;
    logic [N+2:0] w_sel;
    logic         w_unused_hi;

    assign w_t     = {prem_q, rad_q[WIDTH-1 -: 2]};
    assign w_trial = {1'b0, proot_q, 2'b01};
    assign w_diff  = w_t - w_trial;
    // Negative difference restores the shifted remainder.
    assign w_sel   = w_diff[N+2] ? w_t : w_diff;
    // The selected remainder is provably <= 2*root, so its top two bits are
    // always zero and are intentionally dropped.
    assign w_unused_hi = ^w_sel[N+2:N+1];

    always_comb begin
        state_d = state_q;
        rad_d   = rad_q;
        proot_d = proot_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        root_d  = root_q;
        rem_d   = rem_q;

        case (state_q)
            // DONE behaves like IDLE for acceptance so results can stream
            // back-to-back at one per N+1 cycles.
            S_IDLE, S_DONE: begin
                if (start) begin
                    rad_d   = din;
                    proot_d = '0;
                    prem_d  = '0;
                    cnt_d   = CW'(N);
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                prem_d = w_sel[N:0];
                if (!w_diff[N+2]) begin
                    proot_d = (proot_q << 1) | N'(1);
                end else begin
                    proot_d = proot_q << 1;
                end
                rad_d = rad_q << 2;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    root_d  = proot_d;
                    rem_d   = prem_d;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rad_q   <= '0;
            proot_q <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            root_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rad_q   <= rad_d;
            proot_q <= proot_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign root = root_q;
    assign rem  = rem_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_isqrt.sv
// ============================================================================
//  Module   : tb_seq_isqrt
//  Purpose  : Scoreboard bench for seq_isqrt at WIDTH = 8, 16 and 2.
//             Stimulus pushes expected root/rem/done-cycle into per-width
//             queues; independent monitors pop and compare on each done.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_isqrt;

    typedef struct {
        int unsigned din;
        int unsigned root;
        int unsigned rem;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned cyc = 0;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH = 8
    logic        start8 = 1'b0;
    logic [7:0]  din8   = '0;
    logic        busy8, done8;
    logic [3:0]  root8;
    logic [4:0]  rem8;
    // WIDTH = 16
    logic        start16 = 1'b0;
    logic [15:0] din16   = '0;
    logic        busy16, done16;
    logic [7:0]  root16;
    logic [8:0]  rem16;
    // WIDTH = 2
    logic        start2 = 1'b0;
    logic [1:0]  din2   = '0;
    logic        busy2, done2;
    logic [0:0]  root2;
    logic [1:0]  rem2;

    seq_isqrt #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .din(din8),
        .busy(busy8), .done(done8), .root(root8), .rem(rem8)
    );
    seq_isqrt #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .din(din16),
        .busy(busy16), .done(done16), .root(root16), .rem(rem16)
    );
    seq_isqrt #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .din(din2),
        .busy(busy2), .done(done2), .root(root2), .rem(rem2)
    );

    exp_t q8[$];
    exp_t q16[$];
    exp_t q2[$];

    task automatic chk(input string name, input longint unsigned got,
                       input longint unsigned want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: largest r with r*r <= d, found by plain search.
    function automatic int unsigned isqrt_ref(input int unsigned d);
        int unsigned r = 0;
        while ((r + 1) * (r + 1) <= d) r++;
        return r;
    endfunction

    // Build expectation; accept edge is the next posedge, done is seen in
    // the cycle after N further edges.
    function automatic exp_t mk(input int unsigned d, input int unsigned c0,
                                input int unsigned n);
        exp_t e;
        e.din  = d;
        e.root = isqrt_ref(d);
        e.rem  = d - e.root * e.root;
        e.cyc  = c0 + 1 + n;
        return e;
    endfunction

    // ---------------- monitors ----------------
    int unsigned run8 = 0, last_root8 = 0, last_rem8 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            run8 = 0; last_root8 = 0; last_rem8 = 0;
        end else begin
            if (busy8 && done8) chk("w8_busy_and_done", 1, 0);
            if (busy8) run8++;
            if (done8) begin
                if (q8.size() == 0) chk("w8_unexpected_done", 1, 0);
                else begin
                    e = q8.pop_front();
                    chk("w8_root", root8, e.root);
                    chk("w8_rem", rem8, e.rem);
                    chk("w8_latency", cyc, e.cyc);
                    chk("w8_busy_len", run8, 4);
                    chk("w8_identity", root8 * root8 + rem8, e.din);
                    chk("w8_rem_bound", (rem8 <= 2 * root8), 1);
                end
                run8 = 0; last_root8 = root8; last_rem8 = rem8;
            end else begin
                chk("w8_hold_root", root8, last_root8);
                chk("w8_hold_rem", rem8, last_rem8);
            end
        end
    end

    int unsigned run16 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) run16 = 0;
        else begin
            if (busy16 && done16) chk("w16_busy_and_done", 1, 0);
            if (busy16) run16++;
            if (done16) begin
                if (q16.size() == 0) chk("w16_unexpected_done", 1, 0);
                else begin
                    e = q16.pop_front();
                    chk("w16_root", root16, e.root);
                    chk("w16_rem", rem16, e.rem);
                    chk("w16_latency", cyc, e.cyc);
                    chk("w16_busy_len", run16, 8);
                    chk("w16_identity", root16 * root16 + rem16, e.din);
                end
                run16 = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done2) begin
            if (q2.size() == 0) chk("w2_unexpected_done", 1, 0);
            else begin
                e = q2.pop_front();
                chk("w2_root", root2, e.root);
                chk("w2_rem", rem2, e.rem);
                chk("w2_latency", cyc, e.cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge when the DUT is in IDLE or DONE.
    task automatic go8(input int unsigned d);
        start8 = 1'b1;
        din8   = 8'(d);
        q8.push_back(mk(d, cyc, 4));
        @(posedge clk); #1;
        start8 = 1'b0;
        din8   = 8'($urandom);
    endtask

    task automatic wait8();
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) begin ok = 1; break; end
        end
        if (!ok) chk("w8_timeout", 0, 1);
    endtask

    task automatic go16(input int unsigned d);
        start16 = 1'b1;
        din16   = 16'(d);
        q16.push_back(mk(d, cyc, 8));
        @(posedge clk); #1;
        start16 = 1'b0;
        din16   = 16'($urandom);
    endtask

    task automatic wait16();
        bit ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done16) begin ok = 1; break; end
        end
        if (!ok) chk("w16_timeout", 0, 1);
    endtask

    task automatic go2(input int unsigned d);
        start2 = 1'b1;
        din2   = 2'(d);
        q2.push_back(mk(d, cyc, 1));
        @(posedge clk); #1;
        start2 = 1'b0;
        din2   = 2'($urandom);
    endtask

    task automatic wait2();
        bit ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done2) begin ok = 1; break; end
        end
        if (!ok) chk("w2_timeout", 0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_root", root8, 0);
        chk("rst_rem", rem8, 0);
        chk("rst_root16", root16, 0);
        chk("rst_rem16", rem16, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed values, from IDLE
        go8(0);   wait8(); repeat (2) @(negedge clk);
        go8(255); wait8(); repeat (2) @(negedge clk);
        go8(144); wait8();
        go8(200); wait8();   // accepted in DONE

        // Start held high: 50, then 99 presented in the DONE cycle
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        din8   = 8'd50;
        q8.push_back(mk(50, cyc, 4));
        @(posedge clk); #1;
        din8 = 8'($urandom);           // ignored while busy, start still high
        wait8();
        din8 = 8'd99;
        q8.push_back(mk(99, cyc, 4));
        @(posedge clk); #1;
        start8 = 1'b0;
        wait8();

        // Start pulse during CALC must not restart or alter the result
        repeat (2) @(negedge clk);
        go8(200);
        @(negedge clk); @(negedge clk);
        start8 = 1'b1; din8 = 8'd1;
        @(negedge clk);
        start8 = 1'b0;
        wait8();
        repeat (8) @(negedge clk);

        // Reset two cycles into CALC aborts with outputs cleared
        go8(255);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_root", root8, 0);
        chk("abort_rem", rem8, 0);
        q8.delete();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_abort_no_done_root", root8, 0);
        go8(16); wait8();
        repeat (2) @(negedge clk);

        // Exhaustive 8-bit sweep, back-to-back through DONE
        for (int d = 0; d < 256; d++) begin
            go8(d);
            wait8();
        end
        repeat (3) @(negedge clk);

        // 16-bit: corner plus random vectors
        go16(65535); wait16();
        go16(0);     wait16();
        for (int i = 0; i < 1000; i++) begin
            go16($urandom_range(0, 65535));
            wait16();
            if (($urandom & 7) == 0) repeat (2) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // 2-bit
        for (int d = 0; d < 4; d++) begin
            go2(d);
            wait2();
        end
        repeat (2) @(negedge clk);
        go2(3); wait2();
        repeat (4) @(negedge clk);

        chk("q8_drained", q8.size(), 0);
        chk("q16_drained", q16.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
